// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: turns an ALU effective address plus funct3 into a
// single word-bus transaction, and returns a lane-aligned, extended load result.

// Per-byte-lane enable and store data for one lane of the 32-bit word bus.
module lsu_lane #(
  parameter int K = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  output logic        be,
  output logic [7:0]  wbyte
);
  localparam logic [1:0] KL = 2'(K);

  always_comb begin
    be    = 1'b0;
    wbyte = wdata[8*K +: 8];
    case (size)
      2'b00: begin
        be    = (lo == KL);
        wbyte = wdata[7:0];
      end
      2'b01: begin
        be    = (lo[1] == KL[1]);
        wbyte = KL[0] ? wdata[15:8] : wdata[7:0];
      end
      default: begin
        be    = 1'b1;
        wbyte = wdata[8*K +: 8];
      end
    endcase
  end
endmodule

module lsu_bus_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        Busy,
  output logic        Done,
  output logic [1:0]  ErrCode,
  output logic [31:0] ReadData,
  output logic        BusReq,
  output logic        BusWE,
  output logic [31:0] BusAddr,
  output logic [3:0]  BusBE,
  output logic [31:0] BusWData,
  input  logic        BusAck,
  input  logic [31:0] BusRData
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                         state, nxt;
  logic [CNT_W-1:0]               cnt, cnt_inc;
  logic                           tmo;
  logic [1:0]                     lo_q;
  logic [2:0]                     f3_q;
  logic                           we_q, ld_q;
  logic                           illegal, misal, is_load;
  logic [NUM_LANES-1:0]           be_c;
  logic [NUM_LANES-1:0][7:0]      wb_c;
  logic [7:0]                     rbyte;
  logic [15:0]                    rhalf;
  logic [31:0]                    ext;

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      lsu_lane #(.K(k)) u_lane (
        .size  (Funct3[1:0]),
        .lo    (ALUResult[1:0]),
        .wdata (WriteData),
        .be    (be_c[k]),
        .wbyte (wb_c[k])
      );
    end
  endgenerate

  // Access checks are made on the raw inputs in the Start cycle.
  always_comb begin
    is_load = MemRead & ~MemWrite;
    illegal = (MemRead == MemWrite)
            | (MemRead & ((Funct3 == 3'b011) | (Funct3[2:1] == 2'b11)))
            | (MemWrite & Funct3[2]);
    misal   = ((Funct3[1:0] == 2'b01) & ALUResult[0])
            | ((Funct3[1:0] == 2'b10) & (ALUResult[1:0] != 2'b00));
  end

  // Timeout fires on the TIMEOUT-th ack-less REQ cycle; an ack in that same cycle wins.
  always_comb begin
    cnt_inc = cnt + 1'b1;
    tmo     = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));
  end

  always_comb begin
    rbyte = BusRData[{lo_q, 3'b000} +: 8];
    rhalf = lo_q[1] ? BusRData[31:16] : BusRData[15:0];
    case (f3_q)
      3'b000:  ext = {{24{rbyte[7]}}, rbyte};
      3'b001:  ext = {{16{rhalf[15]}}, rhalf};
      3'b100:  ext = {24'h0, rbyte};
      3'b101:  ext = {16'h0, rhalf};
      default: ext = BusRData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt    = state;
    Busy   = (state != IDLE);
    Done   = (state == DONE);
    BusReq = (state == REQ);
    BusWE  = (state == REQ) & we_q;
    case (state)
      IDLE:    if (Start) nxt = (illegal | misal) ? DONE : REQ;
      REQ:     if (BusAck | tmo) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      lo_q     <= '0;
      f3_q     <= '0;
      we_q     <= 1'b0;
      ld_q     <= 1'b0;
      ErrCode  <= 2'b00;
      ReadData <= '0;
      BusAddr  <= '0;
      BusBE    <= '0;
      BusWData <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          lo_q <= ALUResult[1:0];
          f3_q <= Funct3;
          we_q <= MemWrite;
          ld_q <= is_load;
          cnt  <= '0;
          if (illegal) begin
            ErrCode <= 2'b10;
            if (is_load) ReadData <= '0;
          end else if (misal) begin
            ErrCode <= 2'b01;
            if (is_load) ReadData <= '0;
          end else begin
            ErrCode  <= 2'b00;
            BusAddr  <= {ALUResult[31:2], 2'b00};
            BusBE    <= be_c;
            BusWData <= wb_c;
          end
        end
        REQ: begin
          if (BusAck) begin
            ErrCode <= 2'b00;
            if (ld_q) ReadData <= ext;
          end else if (tmo) begin
            ErrCode <= 2'b11;
            if (ld_q) ReadData <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
